// File: rtl/jt10_adpcma_pkg.sv
// Shared constants and types for the ADPCM-A sample ROM bridge.
package jt10_adpcma_pkg;

  // One cache slot per time-multiplexed ADPCM-A channel.
  localparam int CH_NUM = 6;

  // Word tag is {bank[3:0], addr[19:1]}.
  localparam int TAG_W = 23;

  // Lookup/request sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOOK = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/jt10_adpcma_tagram.sv
// Per-slot word cache: {valid, tag, data}. Combinational read, synchronous
// write. Flush clears every valid bit and takes priority over a write.
module jt10_adpcma_tagram
  import jt10_adpcma_pkg::*;
#(
  parameter int CH = CH_NUM,
  parameter int SW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SW-1:0]    rd_slot,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [15:0]      rd_data,
  input  logic [SW-1:0]    wr_slot,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [15:0]      wr_data,
  input  logic             flush
);

  logic [CH-1:0]    valid;
  logic [TAG_W-1:0] tag_mem  [CH];
  logic [15:0]      data_mem [CH];

  // Read port; slot codes beyond CH-1 never occur but read as an invalid entry.
  always_comb begin
    rd_valid = 1'b0;
    rd_tag   = '0;
    rd_data  = '0;
    if (int'(rd_slot) < CH) begin
      rd_valid = valid[rd_slot];
      rd_tag   = tag_mem[rd_slot];
      rd_data  = data_mem[rd_slot];
    end
  end

  // Valid bits: cleared by reset or flush, set by a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (wr_en && (int'(wr_slot) < CH)) begin
      valid[wr_slot] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en && !flush && (int'(wr_slot) < CH)) begin
      tag_mem[wr_slot]  <= wr_tag;
      data_mem[wr_slot] <= wr_data;
    end
  end

endmodule

// File: rtl/jt10_adpcma_romif.sv
// ADPCM-A sample ROM bridge: turns cen-paced byte reads from the driver into
// word requests on the SDRAM arbiter, with a one-word cache per channel slot.
//
// Handshake: sdram_req is a level that rises together with a stable
// sdram_addr and stays high, with sdram_addr unchanged, until the clock in
// which sdram_ok is seen high; sdram_data is taken in that same clock and
// sdram_req drops on the following clock. There is no abort except reset.
module jt10_adpcma_romif
  import jt10_adpcma_pkg::*;
#(
  parameter int              CH     = CH_NUM,
  parameter int              AW     = 23,
  parameter logic [AW-1:0]   BASE_W = '0
) (
  input  logic          rst_n,
  input  logic          clk,
  input  logic          cen,
  input  logic [19:0]   addr,
  input  logic [3:0]    bank,
  input  logic          roe_n,
  input  logic          downloading,
  output logic [7:0]    datain,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ok,
  input  logic [15:0]   sdram_data,
  output logic          late
);

  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  state_t           state;
  logic [SW-1:0]    slot;
  logic             cen_d;
  logic [19:0]      addr_q;
  logic [3:0]       bank_q;
  logic [SW-1:0]    slot_q;
  logic [TAG_W-1:0] tag_q;
  logic             bsel_q;
  // stale: completion must not touch datain (late cen or download seen).
  // drop: completion must not touch the cache either (download seen).
  logic             stale;
  logic             drop;

  logic [TAG_W-1:0] tag_look;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [15:0]      rd_data;
  logic             hit;
  logic             fill_en;

  assign tag_look = {bank_q, addr_q[19:1]};
  assign hit      = rd_valid && (rd_tag == tag_look);
  assign fill_en  = (state == ST_WAIT) && sdram_ok && !drop && !downloading;

  jt10_adpcma_tagram #(
    .CH (CH),
    .SW (SW)
  ) u_tagram (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_slot  (slot),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_slot  (slot_q),
    .wr_en    (fill_en),
    .wr_tag   (tag_q),
    .wr_data  (sdram_data),
    .flush    (downloading)
  );

  // Slot counter follows the driver's channel rotation, one step per cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot  <= '0;
      cen_d <= 1'b0;
    end else begin
      cen_d <= cen;
      if (cen) begin
        slot <= (slot == SW'(CH - 1)) ? '0 : slot + 1'b1;
      end
    end
  end

  // Lookup / request sequencer with registered datain, request and late flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      datain     <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      late       <= 1'b0;
      addr_q     <= '0;
      bank_q     <= '0;
      slot_q     <= '0;
      tag_q      <= '0;
      bsel_q     <= 1'b0;
      stale      <= 1'b0;
      drop       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cen_d && !roe_n && !downloading) begin
            addr_q <= addr;
            bank_q <= bank;
            state  <= ST_LOOK;
          end
        end
        ST_LOOK: begin
          if (downloading) begin
            state <= ST_IDLE;
          end else if (hit) begin
            datain <= addr_q[0] ? rd_data[15:8] : rd_data[7:0];
            state  <= ST_IDLE;
          end else begin
            slot_q     <= slot;
            tag_q      <= tag_look;
            bsel_q     <= addr_q[0];
            stale      <= 1'b0;
            drop       <= 1'b0;
            sdram_req  <= 1'b1;
            sdram_addr <= BASE_W + AW'(tag_look);
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sdram_ok) begin
            // ok wins over a coincident cen: that cen is on time.
            sdram_req <= 1'b0;
            state     <= ST_IDLE;
            if (!stale && !drop && !downloading) begin
              datain <= bsel_q ? sdram_data[15:8] : sdram_data[7:0];
            end
          end else begin
            if (cen) begin
              late  <= 1'b1;
              stale <= 1'b1;
            end
            if (downloading) begin
              stale <= 1'b1;
              drop  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (downloading) begin
        datain <= '0;
      end
    end
  end

endmodule
